dai_playback_ctrl: RTL and testbench

DAI_PLAYBACK_CTRL -- requirements
Module: dai_playback_ctrl

---
 rtl/dai_pkg.sv | 16 +
 rtl/dai_rom_arb.sv | 41 ++++
 rtl/dai_playback_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_dai_playback_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dai_pkg.sv
// Shared types and defaults for the DAI playback controller slice.
package dai_pkg;

    localparam int ADDR_W_DEF   = 18;
    localparam int DATA_W_DEF   = 16;
    localparam int CLIP_END_DEF = 239988;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        FETCH_L,
        FETCH_R,
        PAUSED
    } state_e;

endpackage

// File: rtl/dai_rom_arb.sv
// Shared ROM port: playback fetches win, the host gets every other cycle,
// and host read data is presented one cycle after its grant.
module dai_rom_arb #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              clk_2048,
    input  logic              reset,
    input  logic              fetch_active,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_en,
    output logic              host_gnt,
    output logic              host_valid,
    output logic [DATA_W-1:0] host_rdata
);

    logic host_valid_q, host_valid_d;

    always_comb begin
        // Grant is gated by reset so every output reads 0 while reset is held.
        host_gnt     = host_req & ~fetch_active & ~reset;
        rom_en       = fetch_active | host_gnt;
        rom_address  = fetch_active ? fetch_addr : (host_gnt ? host_addr : '0);
        host_valid_d = host_gnt;
        host_rdata   = host_valid_q ? rom_data : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_2048 or posedge reset) begin
        if (reset) host_valid_q <= 1'b0;
        else       host_valid_q <= host_valid_d;
    end

    assign host_valid = host_valid_q;

endmodule

// File: rtl/dai_playback_ctrl.sv
// Frame-paced stereo playback from a shared ROM: one L/R word pair per
// frame_strobe, with pause/resume/stop, looping and host read access.
module dai_playback_ctrl
    import dai_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_2048,
    input  logic              reset,
    input  logic              frame_strobe,
    input  logic              cmd_start,
    input  logic              cmd_pause,
    input  logic              cmd_stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] clip_start,
    input  logic [ADDR_W-1:0] clip_end,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_gnt,
    output logic              host_valid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] play_addr_q, play_addr_d;
    logic              stop_pend_q, stop_pend_d;
    logic              deliver_q, deliver_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] sample_l_q, sample_l_d;
    logic [DATA_W-1:0] sample_r_q, sample_r_d;
    logic              sample_valid_q, sample_valid_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    logic [ADDR_W-1:0] start_aligned;
    logic [ADDR_W:0]   next_addr;
    logic              fetching;
    logic [ADDR_W-1:0] fetch_addr;
    logic              stop_now;

    assign start_aligned = clip_start & ~{{(ADDR_W-1){1'b0}}, 1'b1};
    assign next_addr     = {1'b0, play_addr_q} + {{(ADDR_W-1){1'b0}}, 2'd2};

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d        = state_q;
        play_addr_d    = play_addr_q;
        stop_pend_d    = stop_pend_q;
        deliver_d      = 1'b0;
        last_d         = 1'b0;
        left_d         = left_q;
        sample_l_d     = sample_l_q;
        sample_r_d     = sample_r_q;
        sample_valid_d = 1'b0;
        done_d         = 1'b0;
        cfg_err_d      = 1'b0;
        stop_now       = 1'b0;
        fetching       = 1'b0;
        fetch_addr     = play_addr_q;

        // The right word arrives the cycle after FETCH_R; publish the pair then.
        if (deliver_q) begin
            sample_l_d     = left_q;
            sample_r_d     = rom_data;
            sample_valid_d = 1'b1;
            done_d         = last_q;
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_stop) begin
                    stop_now = 1'b1;
                end else if (cmd_start) begin
                    if (clip_end < start_aligned) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d     = WAIT_FRAME;
                        play_addr_d = start_aligned;
                    end
                end
            end
            WAIT_FRAME: begin
                if (cmd_stop)          stop_now = 1'b1;
                else if (cmd_pause)    state_d  = PAUSED;
                else if (frame_strobe) state_d  = FETCH_L;
            end
            FETCH_L: begin
                fetching    = 1'b1;
                stop_pend_d = stop_pend_q | cmd_stop;
                state_d     = FETCH_R;
            end
            FETCH_R: begin
                fetching    = 1'b1;
                fetch_addr  = {play_addr_q[ADDR_W-1:1], 1'b1};
                left_d      = rom_data;
                stop_pend_d = 1'b0;
                if (stop_pend_q || cmd_stop) begin
                    state_d    = IDLE;
                    sample_l_d = '0;
                    sample_r_d = '0;
                end else begin
                    deliver_d = 1'b1;
                    if (next_addr > {1'b0, clip_end}) begin
                        if (loop_en) begin
                            play_addr_d = start_aligned;
                            state_d     = WAIT_FRAME;
                        end else begin
                            last_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        play_addr_d = next_addr[ADDR_W-1:0];
                        state_d     = WAIT_FRAME;
                    end
                end
            end
            PAUSED: begin
                if (cmd_stop)       stop_now = 1'b1;
                else if (cmd_start) state_d  = WAIT_FRAME;
            end
            default: state_d = IDLE;
        endcase

        // A stop also cancels a pair that is still in the delivery slot.
        if (stop_now) begin
            state_d        = IDLE;
            sample_l_d     = '0;
            sample_r_d     = '0;
            sample_valid_d = 1'b0;
            done_d         = 1'b0;
        end
    end

    always_ff @(posedge clk_2048 or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            play_addr_q    <= '0;
            stop_pend_q    <= 1'b0;
            deliver_q      <= 1'b0;
            last_q         <= 1'b0;
            left_q         <= '0;
            sample_l_q     <= '0;
            sample_r_q     <= '0;
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            play_addr_q    <= play_addr_d;
            stop_pend_q    <= stop_pend_d;
            deliver_q      <= deliver_d;
            last_q         <= last_d;
            left_q         <= left_d;
            sample_l_q     <= sample_l_d;
            sample_r_q     <= sample_r_d;
            sample_valid_q <= sample_valid_d;
            done_q         <= done_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    dai_rom_arb #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_rom_arb (
        .clk_2048    (clk_2048),
        .reset       (reset),
        .fetch_active(fetching),
        .fetch_addr  (fetch_addr),
        .host_req    (host_req),
        .host_addr   (host_addr),
        .rom_data    (rom_data),
        .rom_address (rom_address),
        .rom_en      (rom_en),
        .host_gnt    (host_gnt),
        .host_valid  (host_valid),
        .host_rdata  (host_rdata)
    );

    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = sample_valid_q;
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_dai_playback_ctrl.sv
// Directed plus randomized bench for dai_playback_ctrl with a behavioural ROM
// and a clip-position model built from pair-count arithmetic.
module tb_dai_playback_ctrl;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk_2048 = 1'b0;
    logic          reset = 1'b1;
    logic          frame_strobe = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_pause = 1'b0;
    logic          cmd_stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] clip_start = '0;
    logic [AW-1:0] clip_end = AW'(dai_pkg::CLIP_END_DEF);
    logic [AW-1:0] rom_address;
    logic          rom_en;
    logic [DW-1:0] rom_data = '0;
    logic          host_req = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic          host_gnt;
    logic          host_valid;
    logic [DW-1:0] host_rdata;
    logic [DW-1:0] sample_l;
    logic [DW-1:0] sample_r;
    logic          sample_valid;
    logic          busy;
    logic          done;
    logic          cfg_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dai_playback_ctrl dut (
        .clk_2048    (clk_2048),
        .reset       (reset),
        .frame_strobe(frame_strobe),
        .cmd_start   (cmd_start),
        .cmd_pause   (cmd_pause),
        .cmd_stop    (cmd_stop),
        .loop_en     (loop_en),
        .clip_start  (clip_start),
        .clip_end    (clip_end),
        .rom_address (rom_address),
        .rom_en      (rom_en),
        .rom_data    (rom_data),
        .host_req    (host_req),
        .host_addr   (host_addr),
        .host_gnt    (host_gnt),
        .host_valid  (host_valid),
        .host_rdata  (host_rdata),
        .sample_l    (sample_l),
        .sample_r    (sample_r),
        .sample_valid(sample_valid),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk_2048 = ~clk_2048;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return DW'(a * 18'd977) ^ 16'h5A3C;
    endfunction

    // Synchronous ROM: data appears the cycle after rom_en.
    always @(posedge clk_2048) if (rom_en) rom_data <= rom_word(rom_address);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_2048);
        #1;
    endtask

    task automatic pulse(input logic st, input logic pa, input logic sp);
        cmd_start = st; cmd_pause = pa; cmd_stop = sp;
        step();
        cmd_start = 1'b0; cmd_pause = 1'b0; cmd_stop = 1'b0;
    endtask

    // One frame: expects the pair at word a three edges after the strobe edge.
    task automatic frame(input logic [AW-1:0] a, input logic exp_done, input string tag);
        int lat;
        frame_strobe = 1'b1;
        step();
        frame_strobe = 1'b0;
        lat = 0;
        while (sample_valid !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(3));
        check({tag, "_l"}, 64'(sample_l), 64'(rom_word(a)));
        check({tag, "_r"}, 64'(sample_r), 64'(rom_word(a + 18'd1)));
        check({tag, "_done"}, 64'(done), 64'(exp_done));
        step();
        check({tag, "_valid_pulse"}, 64'(sample_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] h_addr [6];
        logic          exp_gnt [6];
        logic          exp_val [6];
        logic [AW-1:0] exp_ra [6];
        logic          exp_sv [6];
        logic [AW-1:0] cs, ce;
        int            npairs, nframes, seen;

        // Reset state
        step(); step();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_outs_a", 64'({rom_address, rom_en, host_gnt, host_valid, sample_valid, done, cfg_err}), 64'(0));
        check("rst_outs_b", 64'({host_rdata, sample_l, sample_r}), 64'(0));
        reset = 1'b0;
        step();

        // 1: three-pair clip without loop
        clip_start = 18'd0; clip_end = 18'd5; loop_en = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        check("s1_busy", 64'(busy), 64'(1));
        frame(18'd0, 1'b0, "s1_p0");
        frame(18'd2, 1'b0, "s1_p1");
        frame(18'd4, 1'b1, "s1_p2");
        check("s1_busy_after", 64'(busy), 64'(0));

        // 2: same clip looping
        loop_en = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        frame(18'd0, 1'b0, "s2_p0");
        frame(18'd2, 1'b0, "s2_p1");
        frame(18'd4, 1'b0, "s2_p2");
        frame(18'd0, 1'b0, "s2_p3");
        pulse(1'b0, 1'b0, 1'b1);
        check("s2_stop_busy", 64'(busy), 64'(0));
        check("s2_stop_samples", 64'({sample_l, sample_r}), 64'(0));
        loop_en = 1'b0;

        // 3: host held while a frame is fetched
        pulse(1'b1, 1'b0, 1'b0);
        exp_gnt = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_val = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_sv  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) h_addr[i] = AW'(100 + 7 * i);
        exp_ra = '{h_addr[0], 18'd0, 18'd1, h_addr[3], h_addr[4], h_addr[5]};
        host_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            host_addr    = h_addr[i];
            frame_strobe = (i == 0);
            #1;
            check($sformatf("s3_gnt_c%0d", i), 64'(host_gnt), 64'(exp_gnt[i]));
            check($sformatf("s3_addr_c%0d", i), 64'(rom_address), 64'(exp_ra[i]));
            check($sformatf("s3_hvalid_c%0d", i), 64'(host_valid), 64'(exp_val[i]));
            check($sformatf("s3_hdata_c%0d", i), 64'(host_rdata),
                  64'(exp_val[i] ? rom_word(h_addr[(i + 5) % 6]) : 16'h0));
            check($sformatf("s3_svalid_c%0d", i), 64'(sample_valid), 64'(exp_sv[i]));
            step();
        end
        frame_strobe = 1'b0;
        host_req = 1'b0;
        check("s3_pair", 64'({sample_l, sample_r}), 64'({rom_word(18'd0), rom_word(18'd1)}));
        pulse(1'b0, 1'b0, 1'b1);

        // 4: stop during FETCH_L, then start+stop together in IDLE
        pulse(1'b1, 1'b0, 1'b0);
        frame(18'd0, 1'b0, "s4_p0");
        frame_strobe = 1'b1;
        step();
        frame_strobe = 1'b0;
        check("s4_fetchl_en", 64'({rom_en, rom_address}), 64'({1'b1, 18'd2}));
        pulse(1'b0, 1'b0, 1'b1);
        check("s4_fetchr_busy", 64'(busy), 64'(1));
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (sample_valid === 1'b1) seen++;
        end
        check("s4_no_valid", 64'(seen), 64'(0));
        check("s4_idle", 64'(busy), 64'(0));
        check("s4_samples_zero", 64'({sample_l, sample_r}), 64'(0));
        pulse(1'b1, 1'b0, 1'b1);
        check("s4_start_stop_idle", 64'(busy), 64'(0));

        // 5: pause after pair (2,3), strobes ignored, resume
        pulse(1'b1, 1'b0, 1'b0);
        frame(18'd0, 1'b0, "s5_p0");
        frame(18'd2, 1'b0, "s5_p1");
        pulse(1'b0, 1'b1, 1'b0);
        check("s5_paused_busy", 64'(busy), 64'(1));
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            frame_strobe = 1'b1;
            step();
            frame_strobe = 1'b0;
            if (sample_valid === 1'b1 || rom_en === 1'b1) seen++;
            step();
            if (sample_valid === 1'b1 || rom_en === 1'b1) seen++;
        end
        check("s5_no_valid_paused", 64'(seen), 64'(0));
        check("s5_held", 64'({sample_l, sample_r}), 64'({rom_word(18'd2), rom_word(18'd3)}));
        pulse(1'b1, 1'b0, 1'b0);
        frame(18'd4, 1'b1, "s5_p2");

        // 6: rejected start, then reset asserted in FETCH_R
        clip_start = 18'd8; clip_end = 18'd3;
        pulse(1'b1, 1'b0, 1'b0);
        check("s6_cfg_err", 64'({cfg_err, busy}), 64'({1'b1, 1'b0}));
        step();
        check("s6_cfg_err_pulse", 64'(cfg_err), 64'(0));
        clip_start = 18'd0; clip_end = 18'd5;
        pulse(1'b1, 1'b0, 1'b0);
        frame(18'd0, 1'b0, "s6_p0");
        frame_strobe = 1'b1;
        step();
        frame_strobe = 1'b0;
        step();
        check("s6_in_fetchr", 64'({rom_en, rom_address}), 64'({1'b1, 18'd3}));
        host_req = 1'b1;
        reset = 1'b1;
        #1;
        check("s6_rst_outs_a", 64'({rom_address, rom_en, host_gnt, host_valid, sample_valid, done, cfg_err, busy}), 64'(0));
        check("s6_rst_outs_b", 64'({host_rdata, sample_l, sample_r}), 64'(0));
        step();
        host_req = 1'b0;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            frame_strobe = (i == 1);
            step();
            if (sample_valid === 1'b1 || busy === 1'b1) seen++;
        end
        frame_strobe = 1'b0;
        check("s6_idle_after_reset", 64'(seen), 64'(0));

        // Randomized clips against the pair-count model
        for (int r = 0; r < 5; r++) begin
            cs      = AW'(2 * $urandom_range(0, 20));
            ce      = cs + AW'($urandom_range(0, 9));
            loop_en = 1'($urandom_range(0, 1));
            clip_start = cs; clip_end = ce;
            npairs  = int'(ce - cs) / 2 + 1;
            nframes = loop_en ? npairs + 2 : npairs;
            pulse(1'b1, 1'b0, 1'b0);
            for (int k = 0; k < nframes; k++) begin
                repeat ($urandom_range(0, 3)) step();
                frame(cs + AW'(2 * (k % npairs)), !loop_en && (k == npairs - 1),
                      $sformatf("rnd%0d_f%0d", r, k));
            end
            if (loop_en) pulse(1'b0, 1'b0, 1'b1);
            check($sformatf("rnd%0d_idle", r), 64'(busy), 64'(0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
